// File: rtl/exec_pkg.sv
// Shared constants and encodings for the 8-bit execute/writeback stage.
package exec_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned REG_SEL_W = 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_MUL = 3'd6,
        OP_MOV = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_MUL,
        ST_WB
    } state_e;

endpackage

// File: rtl/shift_add_mul_8.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first.
// product presents the accumulator value being written this cycle, so it
// holds the full result in the same cycle that done is high.
module shift_add_mul_8 #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(W);

    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    // Load operands on start, then add/shift once per cycle for W cycles
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done     = 1'b0;
        if (start) begin
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(W - 1)) begin
                done  = 1'b1;
                run_d = 1'b0;
            end
        end
    end

    // Multiplier state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    assign product = acc_d;

endmodule

// File: rtl/execute_stage_8.sv
// Multi-cycle execute/writeback controller wrapped around register_file_8.
module execute_stage_8 #(
    parameter int unsigned DATA_W    = exec_pkg::DATA_W,
    parameter int unsigned REG_SEL_W = exec_pkg::REG_SEL_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instrValid,
    output logic                 instrReady,
    input  logic [2:0]           opcode,
    input  logic [REG_SEL_W-1:0] rdIn,
    input  logic [REG_SEL_W-1:0] rsIn,
    input  logic [DATA_W-1:0]    inData0,
    input  logic [DATA_W-1:0]    inData1,
    output logic [REG_SEL_W-1:0] rd,
    output logic [REG_SEL_W-1:0] rs,
    output logic                 regWrite,
    output logic [DATA_W-1:0]    writeData,
    output logic                 zeroFlag,
    output logic                 carryFlag,
    output logic                 busy
);

    import exec_pkg::*;

    state_e                 state_q, state_d;
    opcode_e                op_q, op_d;
    logic [REG_SEL_W-1:0]   rd_q, rd_d, rs_q, rs_d;
    logic [DATA_W-1:0]      a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   carry_hold_q, carry_hold_d;
    logic                   zero_q, zero_d, carry_q, carry_d;
    logic [DATA_W:0]        add_ext;
    logic                   mul_start, mul_done;
    logic [2*DATA_W-1:0]    mul_product;

    shift_add_mul_8 #(.W(DATA_W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (inData0),
        .b       (inData1),
        .done    (mul_done),
        .product (mul_product)
    );

    // Next-state, result datapath and flag update
    // wdata_q doubles as the result holding register, so writeData stays put
    // between writebacks without a separate output register.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rd_d         = rd_q;
        rs_d         = rs_q;
        a_d          = a_q;
        b_d          = b_q;
        wdata_d      = wdata_q;
        carry_hold_d = carry_hold_q;
        zero_d       = zero_q;
        carry_d      = carry_q;
        mul_start    = 1'b0;
        add_ext      = {1'b0, a_q} + {1'b0, b_q};

        case (state_q)
            ST_IDLE: begin
                if (instrValid) begin
                    op_d    = opcode_e'(opcode);
                    rd_d    = rdIn;
                    rs_d    = rsIn;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                a_d = inData0;
                b_d = inData1;
                if (op_q == OP_MUL) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        wdata_d      = add_ext[DATA_W-1:0];
                        carry_hold_d = add_ext[DATA_W];
                    end
                    OP_SUB: begin
                        wdata_d      = a_q - b_q;
                        carry_hold_d = (a_q < b_q);
                    end
                    OP_AND: begin
                        wdata_d      = a_q & b_q;
                        carry_hold_d = 1'b0;
                    end
                    OP_OR: begin
                        wdata_d      = a_q | b_q;
                        carry_hold_d = 1'b0;
                    end
                    OP_XOR: begin
                        wdata_d      = a_q ^ b_q;
                        carry_hold_d = 1'b0;
                    end
                    OP_SHL: begin
                        wdata_d      = {a_q[DATA_W-2:0], 1'b0};
                        carry_hold_d = a_q[DATA_W-1];
                    end
                    default: begin
                        wdata_d      = b_q;
                        carry_hold_d = carry_q;
                    end
                endcase
                state_d = ST_WB;
            end
            ST_MUL: begin
                if (mul_done) begin
                    wdata_d      = mul_product[DATA_W-1:0];
                    carry_hold_d = |mul_product[2*DATA_W-1:DATA_W];
                    state_d      = ST_WB;
                end
            end
            ST_WB: begin
                if (op_q != OP_MOV) begin
                    zero_d  = (wdata_q == '0);
                    carry_d = carry_hold_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_ADD;
            rd_q         <= '0;
            rs_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            wdata_q      <= '0;
            carry_hold_q <= 1'b0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            rs_q         <= rs_d;
            a_q          <= a_d;
            b_q          <= b_d;
            wdata_q      <= wdata_d;
            carry_hold_q <= carry_hold_d;
            zero_q       <= zero_d;
            carry_q      <= carry_d;
        end
    end

    assign instrReady = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign regWrite   = (state_q == ST_WB);
    assign writeData  = wdata_q;
    assign rd         = rd_q;
    assign rs         = rs_q;
    assign zeroFlag   = zero_q;
    assign carryFlag  = carry_q;

endmodule

// File: tb/tb_execute_stage_8.sv
// Bench for execute_stage_8 with a 2-entry register file model and a
// scoreboard of expected writebacks.
module tb_execute_stage_8;

    import exec_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       instrValid;
    logic       instrReady;
    logic [2:0] opcode;
    logic       rdIn, rsIn;
    logic [7:0] inData0, inData1;
    logic       rd, rs;
    logic       regWrite;
    logic [7:0] writeData;
    logic       zeroFlag, carryFlag, busy;

    execute_stage_8 #(.DATA_W(8), .REG_SEL_W(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .opcode     (opcode),
        .rdIn       (rdIn),
        .rsIn       (rsIn),
        .inData0    (inData0),
        .inData1    (inData1),
        .rd         (rd),
        .rs         (rs),
        .regWrite   (regWrite),
        .writeData  (writeData),
        .zeroFlag   (zeroFlag),
        .carryFlag  (carryFlag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational reads, write on regWrite
    logic [7:0] rf [2];
    logic       ld_en;
    logic       ld_idx;
    logic [7:0] ld_val;
    always @(posedge clk) begin
        if (ld_en) rf[ld_idx] <= ld_val;
        else if (regWrite) rf[rd] <= writeData;
    end
    assign inData0 = rf[rd];
    assign inData1 = rf[rs];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       rd;
        logic [7:0] data;
        logic       z;
        logic       c;
        int         acc_cyc;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    logic [7:0] exp_rf [2];
    logic       exp_z, exp_c;
    bit         flag_pending;
    int         n_checks = 0;
    int         n_errors = 0;
    int         nr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and score any writeback seen there
    task automatic tick();
        @(negedge clk);
        if (flag_pending) begin
            check_eq("wr_one_cycle", regWrite, 0);
            check_eq("zero_flag", zeroFlag, cur.z);
            check_eq("carry_flag", carryFlag, cur.c);
            flag_pending = 0;
        end
        if (regWrite) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_write", 1, 0);
            end else begin
                cur = sb.pop_front();
                check_eq("wdata", writeData, cur.data);
                check_eq("wr_rd", rd, cur.rd);
                check_eq("latency", cyc - cur.acc_cyc, cur.lat);
                flag_pending = 1;
            end
        end
    endtask

    task automatic model_push(input logic [2:0] op, input logic r_d, input logic r_s);
        logic [7:0]  a, b, res;
        logic [8:0]  s9;
        logic [15:0] p;
        logic        c;
        a = exp_rf[r_d];
        b = exp_rf[r_s];
        c = 1'b0;
        s9 = {1'b0, a} + {1'b0, b};
        p = 16'(a) * 16'(b);
        case (op)
            3'd0: begin res = s9[7:0]; c = s9[8]; end
            3'd1: begin res = a - b; c = (a < b); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: begin res = {a[6:0], 1'b0}; c = a[7]; end
            3'd6: begin res = p[7:0]; c = (p[15:8] != 0); end
            default: res = b;
        endcase
        if (op != 3'd7) begin
            exp_z = (res == 8'd0);
            exp_c = c;
        end
        exp_rf[r_d] = res;
        sb.push_back('{rd: r_d, data: res, z: exp_z, c: exp_c, acc_cyc: cyc,
                       lat: (op == 3'd6) ? 10 : 3});
    endtask

    task automatic preload(input logic idx, input logic [7:0] val);
        ld_en  = 1'b1;
        ld_idx = idx;
        ld_val = val;
        exp_rf[idx] = val;
        tick();
        ld_en = 1'b0;
    endtask

    // Present an instruction, wait for acceptance, return cycles spent not ready
    task automatic issue(input logic [2:0] op, input logic r_d, input logic r_s,
                         input bit keep_valid, input bit push, output int not_ready);
        instrValid = 1'b1;
        opcode     = op;
        rdIn       = r_d;
        rsIn       = r_s;
        not_ready  = 0;
        while (!instrReady && not_ready < 50) begin
            tick();
            not_ready++;
        end
        if (!instrReady) begin
            check_eq("accept_timeout", instrReady, 1);
            instrValid = 1'b0;
        end else begin
            if (push) model_push(op, r_d, r_s);
            tick();
            if (!keep_valid) instrValid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) check_eq("idle_timeout", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; instrValid = 1'b0; opcode = '0; rdIn = 1'b0; rsIn = 1'b0;
        ld_en = 1'b0; ld_idx = 1'b0; ld_val = '0;
        exp_z = 1'b0; exp_c = 1'b0; flag_pending = 0;
        tick();
        tick();
        check_eq("rst_ready", instrReady, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_regwrite", regWrite, 0);
        check_eq("rst_wdata", writeData, 0);
        check_eq("rst_flags", {zeroFlag, carryFlag}, 0);
        check_eq("rst_sel", {rd, rs}, 0);
        rst_n = 1'b1;
        tick();

        // ADD with carry out
        preload(1'b0, 8'd200);
        preload(1'b1, 8'd100);
        issue(3'd0, 1'b0, 1'b1, 0, 1, nr);
        wait_idle();
        check_eq("t1_r0", rf[0], 44);
        check_eq("t1_carry", carryFlag, 1);

        // SUB equal then SUB with borrow
        preload(1'b0, 8'd5);
        preload(1'b1, 8'd5);
        issue(3'd1, 1'b0, 1'b1, 0, 1, nr);
        wait_idle();
        check_eq("t2_zero", zeroFlag, 1);
        preload(1'b0, 8'd3);
        preload(1'b1, 8'd5);
        issue(3'd1, 1'b0, 1'b1, 0, 1, nr);
        wait_idle();
        check_eq("t2_wdata", writeData, 254);

        // MUL without and with overflow
        preload(1'b0, 8'd13);
        preload(1'b1, 8'd11);
        issue(3'd6, 1'b0, 1'b1, 0, 1, nr);
        wait_idle();
        check_eq("t3_wdata", writeData, 143);
        preload(1'b0, 8'd16);
        preload(1'b1, 8'd16);
        issue(3'd6, 1'b0, 1'b1, 0, 1, nr);
        wait_idle();
        check_eq("t3_flags", {zeroFlag, carryFlag}, 2'b11);

        // Back-to-back ADD then MOV with instrValid held
        preload(1'b0, 8'd200);
        preload(1'b1, 8'd100);
        issue(3'd0, 1'b0, 1'b1, 1, 1, nr);
        issue(3'd7, 1'b1, 1'b0, 0, 1, nr);
        check_eq("t4_not_ready", nr, 3);
        wait_idle();
        check_eq("t4_r1", rf[1], 44);
        check_eq("t4_carry", carryFlag, 1);

        // Reset during the 4th MUL cycle discards the instruction
        preload(1'b0, 8'd7);
        preload(1'b1, 8'd9);
        issue(3'd6, 1'b0, 1'b1, 0, 0, nr);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check_eq("t5_ready", instrReady, 1);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_regwrite", regWrite, 0);
        check_eq("t5_wdata", writeData, 0);
        check_eq("t5_flags", {zeroFlag, carryFlag}, 0);
        check_eq("t5_sel", {rd, rs}, 0);
        exp_z = 1'b0;
        exp_c = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check_eq("t5_r0", rf[0], 7);
        check_eq("t5_r1", rf[1], 9);
        issue(3'd0, 1'b0, 1'b1, 0, 1, nr);
        wait_idle();
        check_eq("t5_add", rf[0], 16);

        // SHL with carry, then XOR of a register with itself
        preload(1'b0, 8'h81);
        issue(3'd5, 1'b0, 1'b0, 0, 1, nr);
        wait_idle();
        check_eq("t6_shl", writeData, 2);
        issue(3'd4, 1'b0, 1'b0, 0, 1, nr);
        wait_idle();
        check_eq("t6_xor_zero", zeroFlag, 1);

        tick();
        check_eq("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
